// File: rtl/io_panel_pkg.sv
// Shared definitions for the front-panel controller: display mode type,
// the blank segment pattern, a hex-to-seven-segment encoder and a popcount
// helper for event vectors up to 16 bits wide.
package io_panel_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    MODE_COUNT = 1'b0,
    MODE_BUS   = 1'b1
  } disp_mode_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] seg_hex(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/io_panel_ctrl_btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter and rising-edge
// detect of the debounced level.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset (already release-synchronised)
//   raw_i    : raw asynchronous button level
//   stable_o : debounced level
//   rise_o   : high for the one cycle after stable_o rises (unregistered)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          prev_q;

  // Counter only advances on mismatch; any matching cycle restarts it,
  // so a glitch must persist DEBOUNCE_CYC cycles to be accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_q & ~prev_q;

endmodule

// File: rtl/io_panel_ctrl.sv
// Front-panel controller: debounced buttons and mode toggle, press counter,
// multiplexed seven-segment display, PWM gauge and registered bus adder.
//   clk, rst_n          : clock, asynchronous active-low reset
//   buttons, dips       : raw buttons and DIP switches (NUM_BTN each)
//   toggle_btn          : raw display-mode button
//   cnt_clr             : synchronous clear of press_count
//   in_bus0, in_bus1    : adder operands; in_bus0 nibbles shown in mode 1,
//                         in_bus1[PWM_W-1:0] is the gauge duty
//   seg, digit_en       : active-low segments and digit selects
//   leds, btn_event     : debounced buttons ^ dips, rising-edge pulses
//   press_count         : saturating debounced press count
//   disp_mode           : 0 = show press_count, 1 = show in_bus0
//   out_bus0, out_carry : registered sum and carry
//   gauge_pwm           : PWM output
module io_panel_ctrl
  import io_panel_pkg::*;
#(
  parameter int unsigned NUM_BTN      = 8,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BUS_W        = 32,
  parameter int unsigned PWM_W        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BTN-1:0]    buttons,
  input  logic [NUM_BTN-1:0]    dips,
  input  logic                  toggle_btn,
  input  logic                  cnt_clr,
  input  logic [BUS_W-1:0]      in_bus0,
  input  logic [BUS_W-1:0]      in_bus1,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [NUM_BTN-1:0]    leds,
  output logic [NUM_BTN-1:0]    btn_event,
  output logic [15:0]           press_count,
  output logic                  disp_mode,
  output logic [BUS_W-1:0]      out_bus0,
  output logic                  out_carry,
  output logic                  gauge_pwm
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [PWM_W-1:0] PWM_LAST   = ~PWM_W'(1);

  // Reset release synchroniser; assertion stays asynchronous.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sync_n = rst_sync_q[1];

  logic [NUM_BTN-1:0] btn_stable, btn_rise;
  logic               tog_stable_unused, tog_rise;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk_i   (clk),
      .rst_ni  (rst_sync_n),
      .raw_i   (buttons[i]),
      .stable_o(btn_stable[i]),
      .rise_o  (btn_rise[i])
    );
  end

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_tog (
    .clk_i   (clk),
    .rst_ni  (rst_sync_n),
    .raw_i   (toggle_btn),
    .stable_o(tog_stable_unused),
    .rise_o  (tog_rise)
  );

  logic [NUM_BTN-1:0]    leds_q, leds_d;
  logic [NUM_BTN-1:0]    btn_event_q, btn_event_d;
  logic [15:0]           press_count_q, press_count_d;
  disp_mode_e            disp_mode_q, disp_mode_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic [PWM_W-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0]      duty_q, duty_d;
  logic                  pwm_q, pwm_d;
  logic [BUS_W:0]        sum_q, sum_d;
  logic [NUM_DIGITS-1:0] lead_zero;

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin : p_lead_zero
    logic all_zero;
    all_zero  = 1'b1;
    lead_zero = '0;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      all_zero       = all_zero & (frame_q[4*(k-1) +: 4] == 4'h0);
      lead_zero[k-1] = all_zero;
    end
    lead_zero[0] = 1'b0;
  end

  always_comb begin
    logic [16:0]      cnt_sum;
    logic [3:0]       nib;
    logic             presc_tc;
    logic [PWM_W-1:0] duty_eff;

    leds_d      = btn_stable ^ dips;
    btn_event_d = btn_rise;

    cnt_sum = {1'b0, press_count_q} + 17'(popcount16(16'(btn_event_q)));
    if (cnt_clr)         press_count_d = '0;
    else if (cnt_sum[16]) press_count_d = '1;
    else                 press_count_d = cnt_sum[15:0];

    disp_mode_d = disp_mode_q;
    if (tog_rise) disp_mode_d = (disp_mode_q == MODE_COUNT) ? MODE_BUS : MODE_COUNT;

    // Frame value is captured only on the wrap to digit 0 so a frame never tears.
    presc_tc = (presc_q == PRESC_LAST);
    presc_d  = presc_tc ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    frame_d  = frame_q;
    if (presc_tc) begin
      if (idx_q == IDX_LAST) begin
        idx_d   = '0;
        frame_d = (disp_mode_q == MODE_BUS) ? in_bus0[FW-1:0] : FW'(press_count_q);
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    nib        = frame_q[4*idx_q +: 4];
    seg_d      = (dips[NUM_BTN-1] && lead_zero[idx_q]) ? SEG_BLANK : seg_hex(nib);
    digit_en_d = ~(NUM_DIGITS'(1) << idx_q);

    // Duty is taken live at count 0 so a new period uses the new duty at once.
    duty_eff  = (pwm_cnt_q == '0) ? in_bus1[PWM_W-1:0] : duty_q;
    duty_d    = duty_eff;
    pwm_d     = (pwm_cnt_q < duty_eff);
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);

    sum_d = {1'b0, in_bus0} + {1'b0, in_bus1};
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      leds_q        <= '0;
      btn_event_q   <= '0;
      press_count_q <= '0;
      disp_mode_q   <= MODE_COUNT;
      presc_q       <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      seg_q         <= SEG_BLANK;
      digit_en_q    <= '1;
      pwm_cnt_q     <= '0;
      duty_q        <= '0;
      pwm_q         <= 1'b0;
      sum_q         <= '0;
    end else begin
      leds_q        <= leds_d;
      btn_event_q   <= btn_event_d;
      press_count_q <= press_count_d;
      disp_mode_q   <= disp_mode_d;
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      seg_q         <= seg_d;
      digit_en_q    <= digit_en_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_q        <= duty_d;
      pwm_q         <= pwm_d;
      sum_q         <= sum_d;
    end
  end

  assign leds        = leds_q;
  assign btn_event   = btn_event_q;
  assign press_count = press_count_q;
  assign disp_mode   = disp_mode_q;
  assign seg         = seg_q;
  assign digit_en    = digit_en_q;
  assign gauge_pwm   = pwm_q;
  assign out_bus0    = sum_q[BUS_W-1:0];
  assign out_carry   = sum_q[BUS_W];

endmodule

// File: tb/tb_io_panel_ctrl.sv
// Directed bench for io_panel_ctrl with DEBOUNCE_CYC=4, SCAN_DIV=4,
// NUM_DIGITS=4, PWM_W=4, NUM_BTN=8, BUS_W=32. Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_io_panel_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  buttons = '0;
  logic [7:0]  dips = '0;
  logic        toggle_btn = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [31:0] in_bus0 = '0;
  logic [31:0] in_bus1 = '0;
  logic [7:0]  seg;
  logic [3:0]  digit_en;
  logic [7:0]  leds;
  logic [7:0]  btn_event;
  logic [15:0] press_count;
  logic        disp_mode;
  logic [31:0] out_bus0;
  logic        out_carry;
  logic        gauge_pwm;

  int checks = 0;
  int errors = 0;

  io_panel_ctrl #(
    .NUM_BTN(8), .DEBOUNCE_CYC(4), .NUM_DIGITS(4),
    .SCAN_DIV(4), .BUS_W(32), .PWM_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .dips(dips),
    .toggle_btn(toggle_btn), .cnt_clr(cnt_clr),
    .in_bus0(in_bus0), .in_bus1(in_bus1),
    .seg(seg), .digit_en(digit_en), .leds(leds), .btn_event(btn_event),
    .press_count(press_count), .disp_mode(disp_mode),
    .out_bus0(out_bus0), .out_carry(out_carry), .gauge_pwm(gauge_pwm)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns positioned on the first sample of digit 0 of a new frame.
  task automatic sync_frame();
    logic [3:0] prev;
    bit         found;
    prev  = digit_en;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick(1);
      if (digit_en == 4'hE && prev != 4'hE) found = 1;
      prev = digit_en;
    end
    chk("frame_sync", {31'b0, found}, 32'd1);
  endtask

  task automatic chk_digit(input string tag, input int unsigned k, input logic [7:0] exp_seg);
    logic [3:0] en_exp;
    en_exp = 4'b0001 << k;
    en_exp = ~en_exp;
    chk({tag, "_en"}, {28'b0, digit_en}, {28'b0, en_exp});
    chk({tag, "_seg"}, {24'b0, seg}, {24'b0, exp_seg});
  endtask

  // segs = {digit3, digit2, digit1, digit0}
  task automatic check_frame(input string tag, input logic [31:0] segs);
    for (int unsigned k = 0; k < 4; k++) begin
      tick(k == 0 ? 1 : 4);
      chk_digit(tag, k, segs[8*k +: 8]);
    end
  endtask

  task automatic pwm_run(input logic [3:0] duty, input int exp_hi);
    int hi;
    hi = 0;
    in_bus1 = {28'h0, duty};
    tick(40);
    for (int i = 0; i < 15; i++) begin
      if (gauge_pwm) hi++;
      tick(1);
    end
    chk("pwm_duty", hi, exp_hi);
  endtask

  logic [7:0] ev_acc;
  bit         found;

  initial begin
    // Reset state
    tick(2);
    chk("rst_seg", {24'b0, seg}, 32'hFF);
    chk("rst_digit_en", {28'b0, digit_en}, 32'hF);
    chk("rst_cnt", {16'b0, press_count}, 32'h0);
    chk("rst_mode", {31'b0, disp_mode}, 32'h0);
    rst_n = 1'b1;
    tick(4);

    // Clean press of button 0
    buttons = 8'h01;
    tick(6);
    chk("ev_b0_early", {24'b0, btn_event}, 32'h00);
    tick(1);
    chk("ev_b0", {24'b0, btn_event}, 32'h01);
    chk("cnt_b0_pre", {16'b0, press_count}, 32'h0);
    tick(1);
    chk("ev_b0_once", {24'b0, btn_event}, 32'h00);
    chk("cnt_b0", {16'b0, press_count}, 32'h1);
    chk("leds_b0", {24'b0, leds}, 32'h01);

    // 3-cycle glitch on button 1 is rejected
    ev_acc  = '0;
    buttons = 8'h03;
    tick(3);
    buttons = 8'h01;
    for (int i = 0; i < 15; i++) begin tick(1); ev_acc |= btn_event; end
    chk("glitch_ev", {24'b0, ev_acc}, 32'h00);
    chk("glitch_cnt", {16'b0, press_count}, 32'h1);

    // Release produces no event
    ev_acc  = '0;
    buttons = 8'h00;
    for (int i = 0; i < 15; i++) begin tick(1); ev_acc |= btn_event; end
    chk("fall_ev", {24'b0, ev_acc}, 32'h00);
    chk("fall_leds", {24'b0, leds}, 32'h00);

    // Two simultaneous presses
    buttons = 8'h28;
    tick(7);
    chk("ev_pair", {24'b0, btn_event}, 32'h28);
    tick(1);
    chk("cnt_pair", {16'b0, press_count}, 32'h3);
    buttons = 8'h00;
    tick(15);

    // Saturation from 0xFFFE
    force dut.press_count_q = 16'hFFFE;
    tick(1);
    release dut.press_count_q;
    chk("cnt_preload", {16'b0, press_count}, 32'hFFFE);
    buttons = 8'h28;
    tick(8);
    chk("cnt_sat", {16'b0, press_count}, 32'hFFFF);
    buttons = 8'h00;
    tick(15);

    // Clear wins over an event in the same cycle
    buttons = 8'h04;
    tick(7);
    chk("ev_clr", {24'b0, btn_event}, 32'h04);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    chk("cnt_clr", {16'b0, press_count}, 32'h0);
    buttons = 8'h00;
    tick(15);

    // Mode toggle
    toggle_btn = 1'b1;
    tick(6);
    chk("mode_early", {31'b0, disp_mode}, 32'h0);
    tick(1);
    chk("mode_on", {31'b0, disp_mode}, 32'h1);
    toggle_btn = 1'b0;
    tick(15);
    chk("mode_hold", {31'b0, disp_mode}, 32'h1);

    // Mode 1 display of 0x12A7
    in_bus0 = 32'h0000_12A7;
    sync_frame();
    check_frame("disp_12a7", 32'hF9A488F8);

    // Mid-frame change is deferred to the next frame
    sync_frame();
    tick(1);
    chk_digit("mid_d0", 0, 8'hF8);
    in_bus0 = 32'h0000_3C4B;
    tick(4); chk_digit("mid_d1", 1, 8'h88);
    tick(4); chk_digit("mid_d2", 2, 8'hA4);
    tick(4); chk_digit("mid_d3", 3, 8'hF9);
    sync_frame();
    check_frame("disp_3c4b", 32'hB0C69983);

    // Leading-zero blanking
    dips    = 8'h80;
    in_bus0 = 32'h0000_0005;
    sync_frame();
    check_frame("blank", 32'hFFFFFF92);
    chk("blank_leds", {24'b0, leds}, 32'h80);
    dips = 8'h00;

    // PWM gauge
    pwm_run(4'd0, 0);
    pwm_run(4'd5, 5);
    pwm_run(4'd15, 15);

    // Adder
    in_bus0 = 32'hFFFF_FFFF; in_bus1 = 32'h1;
    tick(1);
    chk("add_wrap", out_bus0, 32'h0);
    chk("add_wrap_c", {31'b0, out_carry}, 32'h1);
    in_bus0 = 32'h1234_5678; in_bus1 = 32'h1111_1111;
    tick(1);
    chk("add_plain", out_bus0, 32'h2345_6789);
    chk("add_plain_c", {31'b0, out_carry}, 32'h0);
    in_bus0 = 32'hFFFF_FFFF; in_bus1 = 32'hFFFF_FFFF;
    tick(1);
    chk("add_max", out_bus0, 32'hFFFF_FFFE);
    chk("add_max_c", {31'b0, out_carry}, 32'h1);

    // Asynchronous reset mid-scan
    in_bus0 = 32'h0000_12A7; in_bus1 = 32'h1; dips = 8'h01;
    tick(7);
    chk("pre_rst_leds", {24'b0, leds}, 32'h01);
    chk("pre_rst_sum", out_bus0, 32'h0000_12A8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", {24'b0, seg}, 32'hFF);
    chk("arst_digit_en", {28'b0, digit_en}, 32'hF);
    chk("arst_leds", {24'b0, leds}, 32'h00);
    chk("arst_ev", {24'b0, btn_event}, 32'h00);
    chk("arst_cnt", {16'b0, press_count}, 32'h0);
    chk("arst_mode", {31'b0, disp_mode}, 32'h0);
    chk("arst_sum", out_bus0, 32'h0);
    chk("arst_carry", {31'b0, out_carry}, 32'h0);
    chk("arst_pwm", {31'b0, gauge_pwm}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick(1);
      if (digit_en != 4'hF) found = 1;
    end
    chk("restart_seen", {31'b0, found}, 32'h1);
    chk("restart_digit", {28'b0, digit_en}, 32'hE);
    chk("restart_seg", {24'b0, seg}, 32'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_panel_ctrl.md
Name: io_panel_ctrl

Overview:
Parametrised front-panel controller for the IO fabric. It handles NUM_BTN buttons and a mode toggle, with synchronisation, debounce and edge detection on each. It counts button presses, drives a time-multiplexed NUM_DIGITS seven-segment display, and produces a PWM gauge. It also keeps the registered bus adder, now with carry-out. It sits between the board IO pins and the demo datapath, and replaces the fixed-width, non-debounced panel logic.

Parameters:
NUM_BTN, 8, number of push buttons, DIP switches and LEDs (1..16)
DEBOUNCE_CYC, 16, consecutive stable cycles needed to accept a new button level (>=2)
NUM_DIGITS, 4, number of seven-segment digits scanned (1..8)
SCAN_DIV, 1024, clk cycles each digit stays lit (>=2)
BUS_W, 32, width of the input and output buses (>=4*NUM_DIGITS)
PWM_W, 8, gauge duty resolution in bits

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
buttons  in  NUM_BTN  raw push buttons, active-high, asynchronous to clk
dips  in  NUM_BTN  DIP switches, active-high, quasi-static
toggle_btn  in  1  raw mode button; each debounced press toggles the display mode
cnt_clr  in  1  synchronous pulse; clears press_count
in_bus0  in  BUS_W  operand A; its low nibbles are displayed in mode 1
in_bus1  in  BUS_W  operand B; in_bus1[PWM_W-1:0] is the gauge duty
seg  out  8  active-low segments {dp,g..a} for the currently enabled digit
digit_en  out  NUM_DIGITS  active-low one-hot digit select
leds  out  NUM_BTN  debounced buttons XOR dips, registered
btn_event  out  NUM_BTN  one-cycle pulse per debounced rising edge
press_count  out  16  saturating count of debounced presses
disp_mode  out  1  current display mode (0 = press_count, 1 = in_bus0)
out_bus0  out  BUS_W  registered in_bus0 + in_bus1, mod 2^BUS_W
out_carry  out  1  registered carry-out of that sum
gauge_pwm  out  1  PWM output with duty in_bus1[PWM_W-1:0] / (2^PWM_W - 1)

Behaviour:
- Reset: rst_n asserts asynchronously. It is released through an internal 2-flop synchroniser, so all logic leaves reset synchronously.
- Reset values:
  - seg = 8'hFF; digit_en = all ones (all digits off).
  - leds, btn_event, press_count, disp_mode, out_bus0, out_carry, gauge_pwm = 0.
  - All debounce states = 0; scan and PWM counters = 0.
- Reset mid-operation returns every output to these values immediately (asynchronous assert).
- Input sync: each button and toggle_btn passes through a 2-flop synchroniser.
- Debounce, per channel:
  - A counter increments while the synced level differs from the stable level, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYC-1 with a mismatch still present, the stable level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYC cycles is never accepted.
  - Latency from a clean raw edge to the stable-level change is 2 + DEBOUNCE_CYC cycles.
- Edges:
  - btn_event[i] is registered and goes high for exactly 1 cycle, one cycle after stable[i] rises.
  - Falling edges produce no event.
- press_count:
  - Each cycle it adds popcount(btn_event) and saturates at 16'hFFFF.
  - cnt_clr has priority over the increment; events in the clear cycle are dropped.
- disp_mode: inverts on each debounced rising edge of toggle_btn, with the same latency as btn_event.
- leds: stable XOR dips, registered, 1 cycle.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1. At terminal count the digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - Digit index k shows nibble k (index 0 = least significant).
  - digit_en[k] = 0 only for the active k; seg and digit_en update in the same cycle.
- Frame latch: the display value is sampled only when the index wraps to 0, so a frame never tears.
  - Mode 0 source: press_count, zero-extended.
  - Mode 1 source: in_bus0[4*NUM_DIGITS-1:0].
- Zero blanking: when dips[NUM_BTN-1] = 1, leading-zero digits above digit 0 show 8'hFF. Digit 0 always shows.
- Segment encoding: standard active-low hex 0..F, with the dp segment off (bit 7 = 1).
- PWM:
  - The counter runs 0..2^PWM_W-2 (period 2^PWM_W-1) and duty is latched when the counter is 0.
  - gauge_pwm = (count < duty), registered.
  - Duty 0 gives a constant low output; duty 2^PWM_W-1 gives a constant high output.
- Adder: {out_carry, out_bus0} <= in_bus0 + in_bus1 (BUS_W+1 bits), 1-cycle latency.

Decomposition:
- Package io_panel_pkg holds:
  - the seven-segment hex-encode function;
  - SEG_BLANK = 8'hFF;
  - a popcount function parametrised up to 16 bits.
- Sub-module btn_debounce (sync + debounce + rise pulse, one channel), parameter DEBOUNCE_CYC. It is instantiated NUM_BTN+1 times (the buttons plus toggle_btn).

Test Plan (DEBOUNCE_CYC=4, SCAN_DIV=4, NUM_DIGITS=4, PWM_W=4):
- buttons[0] raised and held -> btn_event[0] pulses for 1 cycle at edge+7; press_count = 1 at edge+8; leds[0] = 1 (dips = 0).
- buttons[1] raised for 3 cycles only, then low -> no btn_event; press_count unchanged.
- buttons[3] and buttons[5] cleanly pressed in the same cycle -> both btn_event pulse together; press_count += 2. Preload count at 16'hFFFE -> saturates at 16'hFFFF. cnt_clr in an event cycle -> press_count = 0.
- Mode 1 with in_bus0 = 32'h0000_12A7 -> per frame, digit_en cycles E,D,B,7 with seg C0 encodings 7,A,2,1 (F8,88,A4,F9). Change in_bus0 mid-frame -> the new value appears only after the wrap. dips[7] = 1 with in_bus0 = 32'h5 -> digits 1..3 = FF.
- in_bus1[3:0] = 0 / 5 / 15 -> gauge_pwm high for 0 / 5 / 15 of every 15 cycles.
- in_bus0 = 32'hFFFF_FFFF, in_bus1 = 32'h1 -> out_bus0 = 0, out_carry = 1 on the next cycle. Pulse rst_n low mid-scan -> all outputs return to their reset values at once, and scanning restarts at digit 0.
